// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared types, constants and the scan-code to ASCII helper for the PS/2
// keyboard event receiver.
//   ps2_state_e  : frame FSM states
//   ps2_evt_t    : one decoded key event {ext, brk, ascii, code}, 18 bits
//   PS2_*        : prefix, shift and discard scan codes (set 2)
//   ps2_is_discard / ps2_to_ascii : decoder helpers
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] ascii;
    logic [7:0] code;
  } ps2_evt_t;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;
  localparam logic [7:0] PS2_ENTER  = 8'h5A;

  // Keyboard housekeeping bytes that never become key events.
  function automatic logic ps2_is_discard(input logic [7:0] code);
    return (code == PS2_BAT) || (code == PS2_ACK) || (code == PS2_ECHO) ||
           (code == PS2_RESEND) || (code == PS2_ERR0) || (code == PS2_ERR1);
  endfunction

  // Make-code translation; letters are produced lowercase and folded to
  // uppercase afterwards so the table stays a single column.
  function automatic logic [7:0] ps2_to_ascii(input logic [7:0] code, input logic shift);
    logic [7:0] r;
    r = 8'h00;
    case (code)
      8'h1C: r = 8'h61;  8'h32: r = 8'h62;  8'h21: r = 8'h63;  8'h23: r = 8'h64;
      8'h24: r = 8'h65;  8'h2B: r = 8'h66;  8'h34: r = 8'h67;  8'h33: r = 8'h68;
      8'h43: r = 8'h69;  8'h3B: r = 8'h6A;  8'h42: r = 8'h6B;  8'h4B: r = 8'h6C;
      8'h3A: r = 8'h6D;  8'h31: r = 8'h6E;  8'h44: r = 8'h6F;  8'h4D: r = 8'h70;
      8'h15: r = 8'h71;  8'h2D: r = 8'h72;  8'h1B: r = 8'h73;  8'h2C: r = 8'h74;
      8'h3C: r = 8'h75;  8'h2A: r = 8'h76;  8'h1D: r = 8'h77;  8'h22: r = 8'h78;
      8'h35: r = 8'h79;  8'h1A: r = 8'h7A;
      8'h45: r = 8'h30;  8'h16: r = 8'h31;  8'h1E: r = 8'h32;  8'h26: r = 8'h33;
      8'h25: r = 8'h34;  8'h2E: r = 8'h35;  8'h36: r = 8'h36;  8'h3D: r = 8'h37;
      8'h3E: r = 8'h38;  8'h46: r = 8'h39;
      8'h29: r = 8'h20;  8'h5A: r = 8'h0A;  8'h66: r = 8'h08;
      default: r = 8'h00;
    endcase
    if (shift && (r >= 8'h61) && (r <= 8'h7A)) begin
      r = r - 8'h20;
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo
// First-word-fall-through synchronous FIFO. The head entry is always visible
// on rd_data_o while rd_valid_o is high. A write while full is accepted only
// if a read happens in the same cycle.
//   clk, rst     : system clock, synchronous active-high reset (flushes)
//   wr_valid_i   : write request with wr_data_i
//   rd_ready_i   : consumer takes the head entry when rd_valid_o is high
//   rd_valid_o   : FIFO not empty
//   rd_data_o    : head entry
//   full_o       : all DEPTH entries occupied
module ps2_evt_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_ready_i,
  output logic             rd_valid_o,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push;
  logic             pop;

  assign rd_valid_o = (count_q != '0);
  assign full_o     = (count_q == CW'(DEPTH));
  assign pop        = rd_valid_o && rd_ready_i;
  assign push       = wr_valid_i && (!full_o || pop);
  assign rd_data_o  = mem_q[rd_ptr_q];

  // Storage array; no reset needed because count_q gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kbd_events.sv
// ps2_kbd_events
// PS/2 keyboard receiver: synchronises and deglitches the PS/2 pins, frames
// bytes (start, 8 data LSB first, odd parity, stop), decodes E0/F0 prefixes
// into make/break/extended events with shift-aware ASCII, and buffers the
// events in a FWFT FIFO with a valid/ready handshake.
//   clk, rst             : system clock, synchronous active-high reset
//   ps2k_clk, ps2k_data  : raw asynchronous PS/2 pins
//   evt_valid/evt_ready  : event handshake, head fields evt_code/ascii/break/ext
//   err_parity/err_frame : one-cycle error pulses
//   overflow             : sticky, an event was dropped on a full FIFO
module ps2_kbd_events
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2k_clk,
  input  logic       ps2k_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic [7:0] evt_ascii,
  output logic       evt_break,
  output logic       evt_ext,
  output logic       err_parity,
  output logic       err_frame,
  output logic       overflow
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic          clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
  logic          filt_q;
  logic [FW-1:0] flt_cnt_q;
  logic          strobe;

  ps2_state_e    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_ok_q, par_ok_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          byte_vld_q, byte_vld_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;

  logic          ext_q, ext_d, brk_q, brk_d;
  logic          lsh_q, lsh_d, rsh_q, rsh_d;
  logic          push_q, push_d;
  ps2_evt_t      evt_q, evt_d;
  ps2_evt_t      head;
  logic          fifo_full;
  logic          ovf_q;

  // Flip the filtered level only after FILTER_LEN consecutive samples that
  // disagree with it; strobe fires on the cycle the level drops to 0.
  assign strobe = filt_q && !clk_s2_q && (flt_cnt_q == FW'(FILTER_LEN - 1));

  // Two-flop synchronisers and the PS/2 clock deglitch filter.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
      filt_q    <= 1'b1;
      flt_cnt_q <= '0;
    end else begin
      clk_s1_q  <= ps2k_clk;
      clk_s2_q  <= clk_s1_q;
      data_s1_q <= ps2k_data;
      data_s2_q <= data_s1_q;
      if (clk_s2_q == filt_q) begin
        flt_cnt_q <= '0;
      end else if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_q    <= clk_s2_q;
        flt_cnt_q <= '0;
      end else begin
        flt_cnt_q <= flt_cnt_q + FW'(1);
      end
    end
  end

  // Frame FSM next-state: shifts bits on strobe, checks parity/stop and
  // abandons a stalled frame after TIMEOUT_CYC cycles without a strobe.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    par_ok_d   = par_ok_q;
    to_cnt_d   = '0;
    byte_vld_d = 1'b0;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (strobe && !data_s2_q) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (strobe) begin
          shreg_d   = {data_s2_q, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (strobe) begin
          par_ok_d = ^{shreg_q, data_s2_q};
          state_d  = STOP;
        end
      end
      STOP: begin
        if (strobe) begin
          state_d = IDLE;
          if (!par_ok_q)       perr_d     = 1'b1;
          else if (!data_s2_q) ferr_d     = 1'b1;
          else                 byte_vld_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if ((state_q != IDLE) && !strobe) begin
      if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d = IDLE;
        ferr_d  = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end
  end

  // Frame FSM registers and the registered accept/error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      par_ok_q   <= 1'b0;
      to_cnt_q   <= '0;
      byte_vld_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      par_ok_q   <= par_ok_d;
      to_cnt_q   <= to_cnt_d;
      byte_vld_q <= byte_vld_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  // Prefix/shift decoder. shreg_q still holds the accepted byte in the
  // cycle byte_vld_q is high. Extended codes other than Enter have no
  // ASCII, and breaks never carry ASCII.
  always_comb begin
    ext_d  = ext_q;
    brk_d  = brk_q;
    lsh_d  = lsh_q;
    rsh_d  = rsh_q;
    push_d = 1'b0;
    evt_d  = '0;
    if (byte_vld_q) begin
      if (shreg_q == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (shreg_q == PS2_BRK) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (!ps2_is_discard(shreg_q)) begin
          push_d     = 1'b1;
          evt_d.ext  = ext_q;
          evt_d.brk  = brk_q;
          evt_d.code = shreg_q;
          if (!brk_q && (!ext_q || (shreg_q == PS2_ENTER))) begin
            evt_d.ascii = ps2_to_ascii(shreg_q, lsh_q | rsh_q);
          end
          if (!ext_q && (shreg_q == PS2_LSHIFT)) lsh_d = !brk_q;
          if (!ext_q && (shreg_q == PS2_RSHIFT)) rsh_d = !brk_q;
        end
      end
    end
  end

  // Decoder state, staged FIFO write, and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      lsh_q  <= 1'b0;
      rsh_q  <= 1'b0;
      push_q <= 1'b0;
      evt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      ext_q  <= ext_d;
      brk_q  <= brk_d;
      lsh_q  <= lsh_d;
      rsh_q  <= rsh_d;
      push_q <= push_d;
      evt_q  <= evt_d;
      if (push_q && fifo_full && !(evt_valid && evt_ready)) ovf_q <= 1'b1;
    end
  end

  ps2_evt_fifo #(
    .WIDTH($bits(ps2_evt_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_valid_i(push_q),
    .wr_data_i (evt_q),
    .rd_ready_i(evt_ready),
    .rd_valid_o(evt_valid),
    .rd_data_o (head),
    .full_o    (fifo_full)
  );

  assign evt_code   = head.code;
  assign evt_ascii  = head.ascii;
  assign evt_break  = head.brk;
  assign evt_ext    = head.ext;
  assign err_parity = perr_q;
  assign err_frame  = ferr_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_events.sv
// tb_ps2_kbd_events
// Directed bench: drives whole PS/2 frames on the pins and compares decoded
// events, error pulse counts and flags against hand-computed values.
module tb_ps2_kbd_events;

  localparam int FL    = 4;
  localparam int TO    = 400;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2Clk;
  logic       ps2Data;
  logic       evtReady;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic [7:0] evt_ascii;
  logic       evt_break;
  logic       evt_ext;
  logic       err_parity;
  logic       err_frame;
  logic       overflow;

  int checks   = 0;
  int failures = 0;
  int perrCnt  = 0;
  int ferrCnt  = 0;
  int p0;
  int f0;

  ps2_kbd_events #(
    .FILTER_LEN (FL),
    .TIMEOUT_CYC(TO),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2k_clk  (ps2Clk),
    .ps2k_data (ps2Data),
    .evt_valid (evt_valid),
    .evt_ready (evtReady),
    .evt_code  (evt_code),
    .evt_ascii (evt_ascii),
    .evt_break (evt_break),
    .evt_ext   (evt_ext),
    .err_parity(err_parity),
    .err_frame (err_frame),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Count every cycle each error output is high, so a single pulse adds 1.
  always @(posedge clk) begin
    if (err_parity) perrCnt++;
    if (err_frame)  ferrCnt++;
  end

  // Safety net so the run always ends.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mkEvt(input logic ext, input logic brk,
                                        input logic [7:0] ascii, input logic [7:0] code);
    return {14'd0, ext, brk, ascii, code};
  endfunction

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sendBit(input logic b);
    ps2Data = b;
    waitCycles(10);
    ps2Clk = 1'b0;
    waitCycles(20);
    ps2Clk = 1'b1;
    waitCycles(10);
  endtask

  // One full frame; optional bad parity / stop value, and an optional
  // check of evt_valid timing relative to the stop-bit clock fall.
  task automatic applyStimulus(input logic [7:0] b, input logic badPar,
                               input logic stopBit, input logic checkLat);
    logic par;
    par = (~^b) ^ badPar;
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(b[i]);
    sendBit(par);
    if (!checkLat) begin
      sendBit(stopBit);
    end else begin
      ps2Data = stopBit;
      waitCycles(10);
      ps2Clk = 1'b0;
      waitCycles(FL + 3);
      checkOutput("latency_before", 32'(evt_valid), 32'd0);
      waitCycles(1);
      checkOutput("latency_at", 32'(evt_valid), 32'd1);
      waitCycles(20 - FL - 4);
      ps2Clk = 1'b1;
      waitCycles(10);
    end
    ps2Data = 1'b1;
    waitCycles(20);
  endtask

  task automatic popCheck(input string tag, input logic [31:0] exp);
    checkOutput({tag, "_valid"}, 32'(evt_valid), 32'd1);
    checkOutput(tag, {14'd0, evt_ext, evt_break, evt_ascii, evt_code}, exp);
    evtReady = 1'b1;
    waitCycles(1);
    evtReady = 1'b0;
  endtask

  task automatic sendMake(input logic [7:0] b);
    applyStimulus(b, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rst      = 1'b1;
    ps2Clk   = 1'b1;
    ps2Data  = 1'b1;
    evtReady = 1'b0;
    waitCycles(3);
    rst = 1'b0;
    waitCycles(30);
    checkOutput("rst_valid", 32'(evt_valid), 32'd0);
    checkOutput("rst_perr", 32'(err_parity), 32'd0);
    checkOutput("rst_ferr", 32'(err_frame), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);

    $display("[TB] single make with latency");
    applyStimulus(8'h1C, 1'b0, 1'b1, 1'b1);
    popCheck("a_make", mkEvt(1'b0, 1'b0, 8'h61, 8'h1C));
    checkOutput("empty_after_pop", 32'(evt_valid), 32'd0);

    $display("[TB] shift sequence");
    sendMake(8'h12); sendMake(8'h1C); sendMake(8'hF0);
    sendMake(8'h1C); sendMake(8'hF0); sendMake(8'h12);
    popCheck("lshift_make", mkEvt(1'b0, 1'b0, 8'h00, 8'h12));
    popCheck("A_upper", mkEvt(1'b0, 1'b0, 8'h41, 8'h1C));
    popCheck("a_break", mkEvt(1'b0, 1'b1, 8'h00, 8'h1C));
    popCheck("lshift_break", mkEvt(1'b0, 1'b1, 8'h00, 8'h12));
    sendMake(8'h1C);
    popCheck("a_after_shift", mkEvt(1'b0, 1'b0, 8'h61, 8'h1C));
    checkOutput("no_ovf_at_depth", 32'(overflow), 32'd0);

    $display("[TB] extended keys");
    sendMake(8'hE0); sendMake(8'h5A);
    sendMake(8'hE0); sendMake(8'hF0); sendMake(8'h5A);
    sendMake(8'h1C);
    popCheck("ext_enter_make", mkEvt(1'b1, 1'b0, 8'h0A, 8'h5A));
    popCheck("ext_enter_break", mkEvt(1'b1, 1'b1, 8'h00, 8'h5A));
    popCheck("flags_cleared", mkEvt(1'b0, 1'b0, 8'h61, 8'h1C));

    $display("[TB] parity and stop errors");
    p0 = perrCnt;
    f0 = ferrCnt;
    applyStimulus(8'h1C, 1'b1, 1'b1, 1'b0);
    checkOutput("perr_pulse", 32'(perrCnt - p0), 32'd1);
    checkOutput("perr_no_ferr", 32'(ferrCnt - f0), 32'd0);
    checkOutput("perr_no_evt", 32'(evt_valid), 32'd0);
    p0 = perrCnt;
    applyStimulus(8'h1C, 1'b0, 1'b0, 1'b0);
    checkOutput("stop_ferr_pulse", 32'(ferrCnt - f0), 32'd1);
    checkOutput("stop_no_perr", 32'(perrCnt - p0), 32'd0);
    checkOutput("stop_no_evt", 32'(evt_valid), 32'd0);

    $display("[TB] stalled frame timeout");
    f0 = ferrCnt;
    sendBit(1'b0);
    for (int i = 0; i < 4; i++) sendBit(1'(8'h29 >> i));
    ps2Data = 1'b1;
    waitCycles(TO + 50);
    checkOutput("timeout_ferr", 32'(ferrCnt - f0), 32'd1);
    checkOutput("timeout_no_evt", 32'(evt_valid), 32'd0);
    sendMake(8'h29);
    popCheck("space_after_timeout", mkEvt(1'b0, 1'b0, 8'h20, 8'h29));
    checkOutput("timeout_ferr_once", 32'(ferrCnt - f0), 32'd1);

    $display("[TB] discard codes");
    sendMake(8'hAA); sendMake(8'hF0); sendMake(8'hFA); sendMake(8'h1C);
    popCheck("discard_then_make", mkEvt(1'b0, 1'b0, 8'h61, 8'h1C));
    checkOutput("discard_no_extra", 32'(evt_valid), 32'd0);

    $display("[TB] right shift and digits");
    sendMake(8'h59); sendMake(8'h15); sendMake(8'hF0); sendMake(8'h59);
    popCheck("rshift_make", mkEvt(1'b0, 1'b0, 8'h00, 8'h59));
    popCheck("Q_upper", mkEvt(1'b0, 1'b0, 8'h51, 8'h15));
    popCheck("rshift_break", mkEvt(1'b0, 1'b1, 8'h00, 8'h59));
    sendMake(8'h16); sendMake(8'h45); sendMake(8'h66);
    popCheck("digit_1", mkEvt(1'b0, 1'b0, 8'h31, 8'h16));
    popCheck("digit_0", mkEvt(1'b0, 1'b0, 8'h30, 8'h45));
    popCheck("backspace", mkEvt(1'b0, 1'b0, 8'h08, 8'h66));

    $display("[TB] clock glitches");
    f0 = ferrCnt;
    ps2Data = 1'b0;
    for (int g = 0; g < 5; g++) begin
      ps2Clk = 1'b0;
      waitCycles(FL - 1);
      ps2Clk = 1'b1;
      waitCycles(FL + 2);
    end
    ps2Data = 1'b1;
    waitCycles(TO + 50);
    checkOutput("glitch_no_frame", 32'(ferrCnt - f0), 32'd0);
    checkOutput("glitch_no_evt", 32'(evt_valid), 32'd0);
    sendMake(8'h32);
    popCheck("b_after_glitch", mkEvt(1'b0, 1'b0, 8'h62, 8'h32));

    $display("[TB] overflow");
    sendMake(8'h1C); sendMake(8'h32); sendMake(8'h21); sendMake(8'h23); sendMake(8'h24);
    checkOutput("ovf_set", 32'(overflow), 32'd1);
    popCheck("ovf_0", mkEvt(1'b0, 1'b0, 8'h61, 8'h1C));
    popCheck("ovf_1", mkEvt(1'b0, 1'b0, 8'h62, 8'h32));
    popCheck("ovf_2", mkEvt(1'b0, 1'b0, 8'h63, 8'h21));
    popCheck("ovf_3", mkEvt(1'b0, 1'b0, 8'h64, 8'h23));
    checkOutput("ovf_drained", 32'(evt_valid), 32'd0);
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);

    $display("[TB] reset flush");
    sendMake(8'h1C);
    checkOutput("pre_rst_valid", 32'(evt_valid), 32'd1);
    rst = 1'b1;
    waitCycles(1);
    rst = 1'b0;
    waitCycles(1);
    checkOutput("flush_valid", 32'(evt_valid), 32'd0);
    checkOutput("flush_ovf", 32'(overflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
